// File: rtl/dmi_pkg.sv
// Shared encodings for the DMI master: request ops, response status,
// debug-module register addresses, abstractcs fields and FSM states.
package dmi_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2,
      OP_RSVD  = 2'd3
   } dmi_op_e;

   localparam logic [1:0] STS_SUCCESS = 2'd0;
   localparam logic [1:0] STS_FAILED  = 2'd2;
   localparam logic [1:0] STS_BUSY    = 2'd3;

   localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
   localparam logic [6:0] ADDR_COMMAND    = 7'h17;

   localparam int ACS_BUSY_BIT   = 3;
   localparam int ACS_CMDERR_MSB = 2;
   localparam int ACS_CMDERR_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_POLL,
      ST_RESP
   } dmi_state_e;

endpackage

// File: rtl/dmi_master.sv
// DMI master: turns one request into a single DMI access, polls abstractcs
// after a command write, and returns one response with a sticky busy flag.
module dmi_master
   import dmi_pkg::*;
#(
   parameter int unsigned POLL_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [6:0]  req_addr,
   input  logic [31:0] req_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_op,
   output logic [31:0] rsp_data,
   input  logic        dmireset,
   output logic        dmi_wr,
   output logic        dmi_rd,
   output logic [6:0]  dmi_addr,
   output logic [31:0] dmi_wdata,
   input  logic [31:0] dmi_rdata
);

   localparam logic [7:0] LP_POLL_LIMIT = 8'(POLL_LIMIT);

   dmi_state_e  r_state, w_state_next;
   logic [1:0]  r_op, w_op_next;
   logic [6:0]  r_addr, w_addr_next;
   logic [31:0] r_wdata, w_wdata_next;
   logic [1:0]  r_rsp_op, w_rsp_op_next;
   logic [31:0] r_rsp_data, w_rsp_data_next;
   logic [7:0]  r_poll_cnt, w_poll_cnt_next;
   logic        r_sticky;
   logic        w_set_sticky;
   logic        w_reject;
   logic [7:0]  w_poll_num;
   logic        w_acs_busy;
   logic [2:0]  w_acs_cmderr;

   // A dmireset arriving with the request lets that request through.
   assign w_reject     = r_sticky & ~dmireset;
   assign w_poll_num   = r_poll_cnt + 8'd1;
   assign w_acs_busy   = dmi_rdata[ACS_BUSY_BIT];
   assign w_acs_cmderr = dmi_rdata[ACS_CMDERR_MSB:ACS_CMDERR_LSB];

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_op    = r_rsp_op;
   assign rsp_data  = r_rsp_data;

   always_comb begin
      w_state_next    = r_state;
      w_op_next       = r_op;
      w_addr_next     = r_addr;
      w_wdata_next    = r_wdata;
      w_rsp_op_next   = r_rsp_op;
      w_rsp_data_next = r_rsp_data;
      w_poll_cnt_next = r_poll_cnt;
      w_set_sticky    = 1'b0;
      dmi_rd          = 1'b0;
      dmi_wr          = 1'b0;
      dmi_addr        = 7'd0;
      dmi_wdata       = 32'd0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_op_next    = req_op;
               w_addr_next  = req_addr;
               w_wdata_next = req_data;
               if (w_reject) begin
                  w_state_next    = ST_RESP;
                  w_rsp_op_next   = STS_BUSY;
                  w_rsp_data_next = 32'd0;
               end else if (req_op == OP_READ || req_op == OP_WRITE) begin
                  w_state_next = ST_ACCESS;
               end else begin
                  w_state_next    = ST_RESP;
                  w_rsp_op_next   = STS_SUCCESS;
                  w_rsp_data_next = 32'd0;
               end
            end
         end
         ST_ACCESS: begin
            dmi_addr = r_addr;
            if (r_op == OP_WRITE) begin
               dmi_wr    = 1'b1;
               dmi_wdata = r_wdata;
               if (r_addr == ADDR_COMMAND) begin
                  w_state_next    = ST_POLL;
                  w_poll_cnt_next = 8'd0;
               end else begin
                  w_state_next    = ST_RESP;
                  w_rsp_op_next   = STS_SUCCESS;
                  w_rsp_data_next = 32'd0;
               end
            end else begin
               dmi_rd          = 1'b1;
               w_state_next    = ST_RESP;
               w_rsp_op_next   = STS_SUCCESS;
               w_rsp_data_next = dmi_rdata;
            end
         end
         ST_POLL: begin
            dmi_rd   = 1'b1;
            dmi_addr = ADDR_ABSTRACTCS;
            if (!w_acs_busy) begin
               w_state_next    = ST_RESP;
               w_rsp_data_next = dmi_rdata;
               w_rsp_op_next   = (w_acs_cmderr != 3'd0) ? STS_FAILED : STS_SUCCESS;
            end else if (w_poll_num == LP_POLL_LIMIT) begin
               w_state_next    = ST_RESP;
               w_rsp_data_next = dmi_rdata;
               w_rsp_op_next   = STS_BUSY;
               w_set_sticky    = 1'b1;
            end else begin
               w_poll_cnt_next = w_poll_num;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op       <= 2'd0;
         r_addr     <= 7'd0;
         r_wdata    <= 32'd0;
         r_rsp_op   <= 2'd0;
         r_rsp_data <= 32'd0;
         r_poll_cnt <= 8'd0;
      end else begin
         r_op       <= w_op_next;
         r_addr     <= w_addr_next;
         r_wdata    <= w_wdata_next;
         r_rsp_op   <= w_rsp_op_next;
         r_rsp_data <= w_rsp_data_next;
         r_poll_cnt <= w_poll_cnt_next;
      end
   end

   // Setting on a poll timeout takes priority over a coincident dmireset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sticky <= 1'b0;
      end else if (w_set_sticky) begin
         r_sticky <= 1'b1;
      end else if (dmireset) begin
         r_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmi_master.sv
// Self-checking bench for dmi_master: directed table, command/timeout/reset
// sequences, and randomized requests against a behavioural response model.
module tb_dmi_master;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [6:0]  req_addr = 7'd0;
   logic [31:0] req_data = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_op;
   logic [31:0] rsp_data;
   logic        dmireset = 1'b0;
   logic        dmi_wr;
   logic        dmi_rd;
   logic [6:0]  dmi_addr;
   logic [31:0] dmi_wdata;
   logic [31:0] dmi_rdata;

   logic [31:0] slave_mem [0:127];
   logic [31:0] model_mem [0:127];
   logic [31:0] acs_seq [0:15];
   int          acs_len = 0;
   logic [31:0] acs_default = 32'h8;
   int          acs_idx = 0;
   bit          model_sticky = 1'b0;

   int total = 0;
   int bad = 0;
   int viol = 0;

   typedef struct {
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [31:0] data;
      int          hold;
      logic [1:0]  exp_op;
      logic [31:0] exp_data;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   vec_t vecs [5];

   dmi_master #(.POLL_LIMIT(LIMIT)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_op    (rsp_op),
      .rsp_data  (rsp_data),
      .dmireset  (dmireset),
      .dmi_wr    (dmi_wr),
      .dmi_rd    (dmi_rd),
      .dmi_addr  (dmi_addr),
      .dmi_wdata (dmi_wdata),
      .dmi_rdata (dmi_rdata)
   );

   always #5 clk = ~clk;

   // Debug-module model: abstractcs follows a per-command script.
   assign dmi_rdata = (dmi_addr == 7'h16)
                      ? ((acs_idx < acs_len) ? acs_seq[acs_idx[3:0]] : acs_default)
                      : slave_mem[dmi_addr];

   always @(negedge clk) begin
      if (dmi_rd && dmi_wr) viol++;
      if (!dmi_rd && !dmi_wr && (dmi_addr != 7'd0 || dmi_wdata != 32'd0)) viol++;
      if ((dmi_rd || dmi_wr) && (req_ready || rsp_valid)) viol++;
      if (dmi_rd && dmi_wdata != 32'd0) viol++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   task automatic pulse_dmireset();
      dmireset = 1'b1;
      @(negedge clk);
      dmireset = 1'b0;
      model_sticky = 1'b0;
   endtask

   task automatic model(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                        input bit rst_hs, output logic [1:0] e_op, output logic [31:0] e_data,
                        output int e_lat, output int e_rd, output int e_wr);
      logic [31:0] v;
      logic [3:0]  k;
      e_rd = 0; e_wr = 0; e_op = 2'd0; e_data = 32'd0; e_lat = 1;
      if (model_sticky && !rst_hs) begin
         e_op = 2'd3;
         return;
      end
      if (rst_hs) model_sticky = 1'b0;
      if (op == 2'd1) begin
         e_data = model_mem[addr]; e_lat = 2; e_rd = 1;
      end else if (op == 2'd2) begin
         model_mem[addr] = data; e_wr = 1; e_lat = 2;
         if (addr == 7'h17) begin
            for (int i = 1; i <= LIMIT; i++) begin
               k = 4'(i - 1);
               v = (i - 1 < acs_len) ? acs_seq[k] : acs_default;
               e_rd = i; e_lat = 2 + i; e_data = v;
               if (!v[3]) begin
                  e_op = (v[2:0] != 3'd0) ? 2'd2 : 2'd0;
                  break;
               end
               if (i == LIMIT) begin
                  e_op = 2'd3;
                  model_sticky = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [6:0] addr,
                      input logic [31:0] data, input int hold, input bit rst_hs,
                      input logic [1:0] e_op, input logic [31:0] e_data,
                      input int e_lat, input int e_rd, input int e_wr);
      int n, lat, rd_n, wr_n, first;
      bit pend, ok;
      logic [1:0]  got_op;
      logic [31:0] got_data, wr_d;
      logic [6:0]  wr_a;
      n = 0; lat = 0; rd_n = 0; wr_n = 0; first = 0; pend = 0; acs_idx = 0;
      wr_a = 7'd0; wr_d = 32'd0;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data; dmireset = rst_hs;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL %s_req_ready timeout got=0 want=1", tag);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 2'd0; req_addr = 7'd0; req_data = 32'd0; dmireset = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (pend) begin acs_idx++; pend = 0; end
         if (dmi_rd) begin
            rd_n++;
            if (first == 0) first = lat;
            if (dmi_addr == 7'h16) pend = 1;
         end
         if (dmi_wr) begin
            wr_n++;
            if (first == 0) first = lat;
            wr_a = dmi_addr; wr_d = dmi_wdata;
            slave_mem[dmi_addr] = dmi_wdata;
         end
      end while (!rsp_valid && lat < 400);
      if (!rsp_valid) begin
         total++; bad++;
         $display("FAIL %s_rsp_valid timeout got=0 want=1", tag);
         return;
      end
      got_op = rsp_op; got_data = rsp_data; ok = 1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_op !== got_op || rsp_data !== got_data || req_ready || dmi_rd || dmi_wr)
            ok = 0;
      end
      if (hold > 0) chk({tag, "_hold_stable"}, 32'(ok), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_idle_after"}, {30'd0, rsp_valid, req_ready}, 32'd1);
      chk({tag, "_op"}, 32'(got_op), 32'(e_op));
      chk({tag, "_data"}, got_data, e_data);
      chk({tag, "_lat"}, lat, e_lat);
      chk({tag, "_rd"}, rd_n, e_rd);
      chk({tag, "_wr"}, wr_n, e_wr);
      if (e_rd + e_wr > 0) chk({tag, "_strobe_cycle"}, first, 1);
      if (e_wr > 0) begin
         chk({tag, "_wr_addr"}, 32'(wr_a), 32'(addr));
         chk({tag, "_wr_data"}, wr_d, data);
      end
      $display("txn %s op=%0d addr=%h data=%h -> rsp_op=%0d rsp_data=%h lat=%0d rd=%0d wr=%0d",
               tag, op, addr, data, got_op, got_data, lat, rd_n, wr_n);
   endtask

   task automatic run_model(input string tag, input logic [1:0] op, input logic [6:0] addr,
                            input logic [31:0] data, input int hold, input bit rst_hs);
      logic [1:0]  e_op;
      logic [31:0] e_data;
      int e_lat, e_rd, e_wr;
      model(op, addr, data, rst_hs, e_op, e_data, e_lat, e_rd, e_wr);
      run(tag, op, addr, data, hold, rst_hs, e_op, e_data, e_lat, e_rd, e_wr);
   endtask

   initial begin
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [31:0] data;
      int r, n;
      bit ok;

      for (int i = 0; i < 128; i++) begin
         slave_mem[i] = $urandom;
         model_mem[i] = slave_mem[i];
      end
      slave_mem[4] = 32'hDEADBEEF;
      model_mem[4] = 32'hDEADBEEF;

      vecs[0] = '{2'd1, 7'h04, 32'h0,         0, 2'd0, 32'hDEADBEEF, 2, 1, 0};
      vecs[1] = '{2'd2, 7'h10, 32'h8000_0000, 0, 2'd0, 32'h0,        2, 0, 1};
      vecs[2] = '{2'd0, 7'h05, 32'h1234,      0, 2'd0, 32'h0,        1, 0, 0};
      vecs[3] = '{2'd3, 7'h10, 32'hFFFF,      0, 2'd0, 32'h0,        1, 0, 0};
      vecs[4] = '{2'd1, 7'h10, 32'h0,         5, 2'd0, 32'h8000_0000, 2, 1, 0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_op", 32'(rsp_op), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_dmi_ctl", {23'd0, dmi_rd, dmi_wr, dmi_addr}, 32'd0);
      chk("rst_dmi_wdata", dmi_wdata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].op == 2'd2) model_mem[vecs[i].addr] = vecs[i].data;
         run($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].hold, 1'b0,
             vecs[i].exp_op, vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_rd, vecs[i].exp_wr);
      end

      // Command poll completing with cmderr after three busy reads
      acs_seq[0] = 32'h8; acs_seq[1] = 32'h8; acs_seq[2] = 32'h8; acs_seq[3] = 32'h1;
      acs_len = 4;
      model_mem[7'h17] = 32'h1;
      run("cmd_poll", 2'd2, 7'h17, 32'h1, 0, 1'b0, 2'd2, 32'h1, 6, 4, 1);

      // Timeout, sticky reject, dmireset recovery
      acs_len = 0; acs_default = 32'h8;
      model_mem[7'h17] = 32'h2;
      run("timeout", 2'd2, 7'h17, 32'h2, 1, 1'b0, 2'd3, 32'h8, 2 + LIMIT, LIMIT, 1);
      model_sticky = 1'b1;
      run("sticky_reject", 2'd1, 7'h04, 32'h0, 0, 1'b0, 2'd3, 32'h0, 1, 0, 0);
      pulse_dmireset();
      run("after_dmireset", 2'd1, 7'h04, 32'h0, 0, 1'b0, 2'd0, 32'hDEADBEEF, 2, 1, 0);

      // dmireset coincident with the request handshake
      run_model("timeout2", 2'd2, 7'h17, 32'h3, 0, 1'b0);
      run_model("rst_at_hs", 2'd1, 7'h04, 32'h0, 0, 1'b1);

      // Randomized requests against the model
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         addr = 7'($urandom_range(0, 15));
         data = $urandom;
         if (r < 3) op = 2'd1;
         else if (r < 6) op = 2'd2;
         else if (r < 8) begin
            op = 2'd2; addr = 7'h17;
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) acs_seq[j] = $urandom | 32'h8;
            acs_seq[n] = $urandom & 32'hFFFF_FFF7;
            acs_len = n + 1;
         end
         else if (r == 8) op = 2'd0;
         else op = 2'd3;
         if ($urandom_range(0, 5) == 0) pulse_dmireset();
         run_model($sformatf("rnd%0d", k), op, addr, data, $urandom_range(0, 3),
                   $urandom_range(0, 4) == 0);
      end

      // Reset in the middle of a poll
      pulse_dmireset();
      acs_len = 0; acs_default = 32'h8;
      req_valid = 1'b1; req_op = 2'd2; req_addr = 7'h17; req_data = 32'h5;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 2'd0; req_addr = 7'd0; req_data = 32'd0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_poll_rd", {24'd0, dmi_rd, dmi_addr}, {24'd0, 1'b1, 7'h16});
      reset_n = 1'b0;
      #1;
      chk("rst_drop_strobes", {22'd0, dmi_rd, dmi_wr, rsp_valid, dmi_addr}, 32'd0);
      chk("rst_drop_wdata", dmi_wdata, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready), 32'd1);
      ok = 1;
      repeat (6) begin
         if (rsp_valid || dmi_rd || dmi_wr) ok = 0;
         @(negedge clk);
      end
      chk("no_rsp_after_rst", 32'(ok), 32'd1);
      model_sticky = 1'b0;
      model_mem[7'h17] = 32'h5;

      // Reset clears sticky busy
      run_model("timeout3", 2'd2, 7'h17, 32'h6, 0, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      model_sticky = 1'b0;
      run_model("read_after_rst", 2'd1, 7'h04, 32'h0, 0, 1'b0);

      chk("protocol_viol", viol, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/dmi_master.md
DMI_MASTER -- requirements
Module: dmi_master

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 255, meaning the maximum abstractcs polls after a command write (legal range 1..255).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  request offered.
REQ-005 SHALL have port req_ready  out  1  request accepted when high together with req_valid.
REQ-006 SHALL have port req_op  in  2  request op: 0 nop, 1 read, 2 write, 3 reserved (treated as nop).
REQ-007 SHALL have port req_addr  in  7  DMI register address.
REQ-008 SHALL have port req_data  in  32  write data.
REQ-009 SHALL have port rsp_valid  out  1  response available.
REQ-010 SHALL have port rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-011 SHALL have port rsp_op  out  2  status: 0 success, 2 failed, 3 busy.
REQ-012 SHALL have port rsp_data  out  32  read data or final abstractcs value.
REQ-013 SHALL have port dmireset  in  1  single-cycle pulse that clears the sticky busy flag.
REQ-014 SHALL have ports dmi_wr out 1, dmi_rd out 1, dmi_addr out 7 and dmi_wdata out 32: the DMI strobes, address and write data.
REQ-015 SHALL have port dmi_rdata  in  32  DMI read data, combinationally valid in the same cycle as dmi_addr.

Function
REQ-016 SHALL implement states IDLE, ACCESS, POLL and RESP.
REQ-017 SHALL drive req_ready high only in IDLE.
REQ-018 On an IDLE handshake, SHALL register op, address and data, then go to:
- RESP with rsp_op 3 and rsp_data 0, if sticky busy is set after this cycle's dmireset;
- RESP with rsp_op 0 and rsp_data 0, if op is nop or reserved;
- ACCESS otherwise.
REQ-019 In ACCESS, SHALL assert exactly one of dmi_rd or dmi_wr for exactly one cycle, with dmi_addr and dmi_wdata (writes only) taken from the request.
REQ-020 On a read in ACCESS, SHALL capture dmi_rdata at the end of the ACCESS cycle into rsp_data and set rsp_op 0.
REQ-021 After a write in ACCESS, SHALL go to POLL if the address is 0x17 (command); otherwise it SHALL go to RESP with rsp_op 0 and rsp_data 0.
REQ-022 In POLL, SHALL assert dmi_rd with dmi_addr 0x16 every cycle and sample dmi_rdata the same cycle.
- Busy is bit 3; cmderr is bits [2:0].
REQ-023 In POLL, SHALL go to RESP when busy is 0, with rsp_data = sampled value and rsp_op = 2 if cmderr != 0, else 0.
REQ-024 In POLL, SHALL count polls in an 8-bit counter.
- If busy is still 1 on poll number POLL_LIMIT: go to RESP with rsp_op 3 and rsp_data = sampled value, and set sticky busy.
REQ-025 In RESP, SHALL hold rsp_valid high with rsp_op and rsp_data stable until rsp_ready; it SHALL return to IDLE in the cycle after the handshake.
REQ-026 Latency SHALL be:
- read or plain write: handshake in cycle T, DMI strobe in T+1, rsp_valid in T+2;
- nop or sticky-busy reject: rsp_valid in T+1.
REQ-027 dmireset SHALL clear sticky busy in any state and SHALL NOT abort an operation in progress.
- If sticky busy is being set the same cycle, setting wins.
REQ-028 dmi_wr and dmi_rd SHALL never be high in the same cycle and SHALL be low in IDLE and RESP.
REQ-029 dmi_addr and dmi_wdata SHALL be 0 whenever no strobe is asserted.

Reset
REQ-030 While reset_n is low, SHALL set state IDLE and the poll counter and sticky busy to 0.
REQ-031 While reset_n is low, SHALL drive all outputs 0 except req_ready.
- req_ready goes high in the first cycle after deassertion.
REQ-032 A reset mid-operation SHALL abandon the operation without a response and without any further DMI strobe.

Structure
REQ-033 SHALL place the following in shared package dmi_pkg:
- op and status encodings;
- addresses ABSTRACTCS=0x16 and COMMAND=0x17;
- abstractcs bit positions (busy bit 3, cmderr [2:0]);
- the state enum.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 Read test: read 0x04 while dmi_rdata=0xDEADBEEF -> dmi_rd pulses one cycle at T+1; rsp_valid at T+2 with rsp_data 0xDEADBEEF and rsp_op 0.
REQ-036 Write test: write 0x10 data 0x80000000 -> single dmi_wr with that data; rsp_op 0.
REQ-037 Command poll: write 0x17; abstractcs reads 0x8 three times, then 0x1 -> exactly 4 polls at 0x16; rsp_op 2; rsp_data 0x1.
REQ-038 Timeout: POLL_LIMIT=4; busy stuck at 1 -> 4 polls, rsp_op 3, sticky set.
- The next read returns rsp_op 3 with no DMI strobe.
- After a dmireset pulse, a read succeeds.
REQ-039 Backpressure: rsp_ready held low for 5 cycles -> rsp_valid, rsp_op and rsp_data stable, req_ready low.
REQ-040 Reset: reset_n asserted mid-POLL -> strobes drop immediately, no response is produced, IDLE after deassertion.
